// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage between EXE and WB. Latches the
//            EXE result, waits for the data-SRAM response of an issued
//            load/store, extracts and extends load data, and passes the
//            result to WB over a valid/allowin handshake. SRAM responses
//            orphaned by a WB flush are counted and silently dropped. Also
//            drives the ID forwarding / load-use stall bus.
// Ports    :
//   clk_i, resetn_i            clock, asynchronous active-low reset
//   es_to_ms_valid_i           EXE offers an instruction
//   ms_allowin_o               stage can accept from EXE this cycle
//   es_payload_i               sideband fields carried through unmodified
//   es_mem_req_i               instruction has an accepted SRAM request
//   es_load_op_i/_uns_i        load size (00 none,01 b,10 h,11 w), zero-ext
//   es_addr_lo_i               data address bits [1:0]
//   es_alu_result_i            non-load writeback value
//   es_gr_we_i, es_dest_i      GPR write enable / destination
//   data_sram_data_ok_i/_rdata_i  in-order SRAM response
//   flush_i                    WB exception / ertn / refetch
//   ws_allowin_i               WB can accept
//   ms_to_ws_*_o               registered instruction + final result to WB
//   ms_fwd_*_o                 forwarding bus toward ID
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int PAYLOAD_W = 180,
  parameter int DISC_W    = 2
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 es_to_ms_valid_i,
  output logic                 ms_allowin_o,
  input  logic [PAYLOAD_W-1:0] es_payload_i,
  input  logic                 es_mem_req_i,
  input  logic [1:0]           es_load_op_i,
  input  logic                 es_load_uns_i,
  input  logic [1:0]           es_addr_lo_i,
  input  logic [31:0]          es_alu_result_i,
  input  logic                 es_gr_we_i,
  input  logic [4:0]           es_dest_i,
  input  logic                 data_sram_data_ok_i,
  input  logic [31:0]          data_sram_rdata_i,
  input  logic                 flush_i,
  input  logic                 ws_allowin_i,
  output logic                 ms_to_ws_valid_o,
  output logic [PAYLOAD_W-1:0] ms_to_ws_payload_o,
  output logic [31:0]          ms_to_ws_result_o,
  output logic                 ms_to_ws_gr_we_o,
  output logic [4:0]           ms_to_ws_dest_o,
  output logic                 ms_fwd_valid_o,
  output logic                 ms_fwd_block_o,
  output logic [4:0]           ms_fwd_dest_o,
  output logic [31:0]          ms_fwd_data_o
);

  // One guard bit for the decrement and one for the double increment.
  localparam int c_SUM_W = DISC_W + 2;
  localparam logic [c_SUM_W-1:0] c_DISC_MAX = c_SUM_W'((1 << DISC_W) - 1);

  logic                 ms_valid_q, ms_valid_d;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 mem_req_q;
  logic [1:0]           load_op_q;
  logic                 load_uns_q;
  logic [1:0]           addr_lo_q;
  logic [31:0]          alu_result_q;
  logic                 gr_we_q;
  logic [4:0]           dest_q;
  logic [31:0]          data_buf_q, data_buf_d;
  logic                 data_buf_vld_q, data_buf_vld_d;
  logic [DISC_W-1:0]    disc_cnt_q, disc_cnt_d;

  logic                 w_disc_zero;
  logic                 w_rsp_take;
  logic                 w_rsp_drop;
  logic                 w_ready_go;
  logic                 w_allowin;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_pend_self;
  logic                 w_pend_exe;
  logic [c_SUM_W-1:0]   w_disc_sum;
  logic [31:0]          w_word;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_result;

  // Responses arrive in order, so while older orphans are outstanding the
  // head response is never ours; once the count is zero it always is.
  assign w_disc_zero = (disc_cnt_q == '0);
  assign w_rsp_take  = data_sram_data_ok_i & w_disc_zero;
  assign w_rsp_drop  = data_sram_data_ok_i & ~w_disc_zero;

  assign w_ready_go  = ~mem_req_q | data_buf_vld_q | w_rsp_take;
  assign w_allowin   = ~ms_valid_q | (w_ready_go & ws_allowin_i);
  assign w_accept    = es_to_ms_valid_i & w_allowin & ~flush_i;
  assign w_capture   = w_rsp_take & ms_valid_q & mem_req_q & ~data_buf_vld_q;

  // Requests that will still produce a response after a flush kills them:
  // our own unanswered one, and the one EXE already issued.
  assign w_pend_self = ms_valid_q & mem_req_q & ~data_buf_vld_q & ~w_rsp_take;
  assign w_pend_exe  = es_to_ms_valid_i & es_mem_req_i;

  always_comb begin
    w_disc_sum = c_SUM_W'(disc_cnt_q) - c_SUM_W'(w_rsp_drop);
    if (flush_i) begin
      w_disc_sum = w_disc_sum + c_SUM_W'(w_pend_self) + c_SUM_W'(w_pend_exe);
    end
    disc_cnt_d = w_disc_sum[DISC_W-1:0];
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (flush_i) begin
      ms_valid_d = 1'b0;
    end else if (w_allowin) begin
      ms_valid_d = es_to_ms_valid_i;
    end
  end

  always_comb begin
    data_buf_d     = data_buf_q;
    data_buf_vld_d = data_buf_vld_q;
    if (w_capture) begin
      data_buf_d     = data_sram_rdata_i;
      data_buf_vld_d = 1'b1;
    end
    if (w_accept) begin
      data_buf_vld_d = 1'b0;
    end
  end

  // Held data wins; otherwise the live response is bypassed straight to WB.
  always_comb begin
    w_word = data_buf_vld_q ? data_buf_q : data_sram_rdata_i;
    case (addr_lo_q)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = addr_lo_q[1] ? w_word[31:16] : w_word[15:0];
    case (load_op_q)
      2'b01:   w_result = {{24{w_byte[7] & ~load_uns_q}}, w_byte};
      2'b10:   w_result = {{16{w_half[15] & ~load_uns_q}}, w_half};
      2'b11:   w_result = w_word;
      default: w_result = alu_result_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ms_valid_q     <= 1'b0;
      payload_q      <= '0;
      mem_req_q      <= 1'b0;
      load_op_q      <= 2'b00;
      load_uns_q     <= 1'b0;
      addr_lo_q      <= 2'b00;
      alu_result_q   <= 32'd0;
      gr_we_q        <= 1'b0;
      dest_q         <= 5'd0;
      data_buf_q     <= 32'd0;
      data_buf_vld_q <= 1'b0;
      disc_cnt_q     <= '0;
    end else begin
      ms_valid_q     <= ms_valid_d;
      data_buf_q     <= data_buf_d;
      data_buf_vld_q <= data_buf_vld_d;
      disc_cnt_q     <= disc_cnt_d;
      if (w_accept) begin
        payload_q    <= es_payload_i;
        mem_req_q    <= es_mem_req_i;
        load_op_q    <= es_load_op_i;
        load_uns_q   <= es_load_uns_i;
        addr_lo_q    <= es_addr_lo_i;
        alu_result_q <= es_alu_result_i;
        gr_we_q      <= es_gr_we_i;
        dest_q       <= es_dest_i;
      end
    end
  end

  // More orphans than the counter can hold means the pipeline issued
  // requests it should not have; flag it rather than silently wrap.
  a_disc_no_overflow: assert property (
    @(posedge clk_i) disable iff (!resetn_i) w_disc_sum <= c_DISC_MAX
  );

  assign ms_allowin_o       = w_allowin;
  assign ms_to_ws_valid_o   = ms_valid_q & w_ready_go & ~flush_i;
  assign ms_to_ws_payload_o = payload_q;
  assign ms_to_ws_result_o  = w_result;
  assign ms_to_ws_gr_we_o   = gr_we_q;
  assign ms_to_ws_dest_o    = dest_q;
  assign ms_fwd_valid_o     = ms_valid_q & gr_we_q & (dest_q != 5'd0);
  assign ms_fwd_block_o     = ms_valid_q & gr_we_q & (load_op_q != 2'b00) & ~w_ready_go;
  assign ms_fwd_dest_o      = dest_q;
  assign ms_fwd_data_o      = w_result;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: reset state, a table of
//            load-extract vectors, hand-written multi-cycle sequences, and a
//            random phase checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int PW = 180;

  logic          clk = 1'b0;
  logic          resetn;
  logic          es_valid, es_mem_req, es_uns, es_we;
  logic [1:0]    es_op, es_lo;
  logic [PW-1:0] es_pay;
  logic [31:0]   es_alu, rdata;
  logic [4:0]    es_dest;
  logic          data_ok, flush, ws_allowin;
  logic          ms_allowin, to_ws_valid, to_ws_we, fwd_valid, fwd_block;
  logic [PW-1:0] to_ws_pay;
  logic [31:0]   to_ws_result, fwd_data;
  logic [4:0]    to_ws_dest, fwd_dest;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.PAYLOAD_W(PW), .DISC_W(2)) dut (
    .clk_i               (clk),
    .resetn_i            (resetn),
    .es_to_ms_valid_i    (es_valid),
    .ms_allowin_o        (ms_allowin),
    .es_payload_i        (es_pay),
    .es_mem_req_i        (es_mem_req),
    .es_load_op_i        (es_op),
    .es_load_uns_i       (es_uns),
    .es_addr_lo_i        (es_lo),
    .es_alu_result_i     (es_alu),
    .es_gr_we_i          (es_we),
    .es_dest_i           (es_dest),
    .data_sram_data_ok_i (data_ok),
    .data_sram_rdata_i   (rdata),
    .flush_i             (flush),
    .ws_allowin_i        (ws_allowin),
    .ms_to_ws_valid_o    (to_ws_valid),
    .ms_to_ws_payload_o  (to_ws_pay),
    .ms_to_ws_result_o   (to_ws_result),
    .ms_to_ws_gr_we_o    (to_ws_we),
    .ms_to_ws_dest_o     (to_ws_dest),
    .ms_fwd_valid_o      (fwd_valid),
    .ms_fwd_block_o      (fwd_block),
    .ms_fwd_dest_o       (fwd_dest),
    .ms_fwd_data_o       (fwd_data)
  );

  typedef struct {
    logic [1:0]  op;
    logic        uns;
    logic [1:0]  lo;
    logic [31:0] rd;
    logic [31:0] alu;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [PW-1:0] pay;
    logic          mem;
    logic [1:0]    op;
    logic          uns;
    logic [1:0]    lo;
    logic [31:0]   alu;
    logic          we;
    logic [4:0]    dest;
    logic [31:0]   rd;
    int            id;
  } ins_t;

  typedef struct {
    int          id;
    logic [31:0] rd;
  } rsp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_valid = 0; es_mem_req = 0; es_op = 0; es_uns = 0; es_lo = 0;
    es_alu = 0; es_we = 0; es_dest = 0; es_pay = '0;
    data_ok = 0; rdata = 0; flush = 0; ws_allowin = 1;
  endtask

  function automatic logic [PW-1:0] rand_pay();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  // Load value as an architectural read: shift the addressed bytes down,
  // mask to size, and add the sign-extension bits when signed and negative.
  function automatic logic [31:0] ld_model(input logic [1:0] op, input logic uns,
                                           input logic [1:0] lo, input logic [31:0] word,
                                           input logic [31:0] alu);
    int unsigned v;
    v = word >> (8 * lo);
    case (op)
      2'd0: return alu;
      2'd1: begin
        v = v % 256;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        return v;
      end
      2'd2: begin
        v = v % 65536;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        return v;
      end
      default: return word;
    endcase
  endfunction

  function automatic ins_t gen_ins(input int id);
    ins_t  n;
    int    kind;
    kind   = $urandom_range(0, 2);
    n.pay  = rand_pay();
    n.alu  = $urandom();
    n.rd   = $urandom();
    n.dest = 5'($urandom_range(0, 31));
    n.uns  = 1'($urandom_range(0, 1));
    n.id   = id;
    n.op   = 2'd0;
    n.lo   = 2'd0;
    if (kind == 1) begin
      n.mem = 1; n.we = 1;
      n.op  = 2'($urandom_range(1, 3));
      if (n.op == 2'd1) n.lo = 2'($urandom_range(0, 3));
      else if (n.op == 2'd2) n.lo = 2'($urandom_range(0, 1) * 2);
    end else if (kind == 2) begin
      n.mem = 1; n.we = 0;
    end else begin
      n.mem = 0; n.we = 1'($urandom_range(0, 1));
    end
    return n;
  endfunction

  vec_t          vt[9];
  logic [PW-1:0] saved_pay;
  ins_t          exe, res;
  bit            exe_v, occ, got, fl, dok, arrive, rdy, exp_valid, exp_allow;
  rsp_t          sq[$];
  int            nid;

  initial begin
    vt[0] = '{2'd3, 1'b0, 2'd0, 32'h1234_5678, 32'h0, 3, 32'h1234_5678};
    vt[1] = '{2'd1, 1'b0, 2'd3, 32'h8000_0000, 32'h0, 1, 32'hFFFF_FF80};
    vt[2] = '{2'd1, 1'b1, 2'd3, 32'h8000_0000, 32'h0, 2, 32'h0000_0080};
    vt[3] = '{2'd2, 1'b0, 2'd2, 32'h8001_ABCD, 32'h0, 1, 32'hFFFF_8001};
    vt[4] = '{2'd2, 1'b1, 2'd0, 32'h0000_F00F, 32'h0, 0, 32'h0000_F00F};
    vt[5] = '{2'd1, 1'b0, 2'd1, 32'h0000_7F00, 32'h0, 1, 32'h0000_007F};
    vt[6] = '{2'd2, 1'b0, 2'd0, 32'h1234_7FFF, 32'h0, 2, 32'h0000_7FFF};
    vt[7] = '{2'd0, 1'b0, 2'd0, 32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vt[8] = '{2'd1, 1'b0, 2'd2, 32'h00AB_0000, 32'h0, 1, 32'hFFFF_FFAB};

    // ---------------- reset state ----------------
    resetn = 1;
    idle();
    #1 resetn = 0;
    #1;
    chk("rst_valid",     to_ws_valid,  0);
    chk("rst_allowin",   ms_allowin,   1);
    chk("rst_result",    to_ws_result, 0);
    chk("rst_dest",      to_ws_dest,   0);
    chk("rst_we",        to_ws_we,     0);
    chk_w("rst_payload", to_ws_pay,    '0);
    chk("rst_fwd_valid", fwd_valid,    0);
    chk("rst_fwd_block", fwd_block,    0);
    chk("rst_fwd_data",  fwd_data,     0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;

    // ---------------- table: load extract / latency ----------------
    for (int i = 0; i < 9; i++) begin
      step();
      idle();
      saved_pay  = rand_pay();
      es_valid   = 1; es_pay = saved_pay;
      es_op      = vt[i].op; es_uns = vt[i].uns; es_lo = vt[i].lo;
      es_alu     = vt[i].alu; es_mem_req = (vt[i].op != 2'd0);
      es_we      = 1; es_dest = 5'(i + 1);
      #1 chk("vec_allowin", ms_allowin, 1);
      step();
      es_valid = 0; es_mem_req = 0;
      if (vt[i].op != 2'd0) begin
        for (int d = 0; d < vt[i].delay; d++) begin
          #1;
          chk("vec_wait_valid", to_ws_valid, 0);
          chk("vec_wait_block", fwd_block,   1);
          step();
        end
        data_ok = 1; rdata = vt[i].rd;
      end
      #1;
      chk("vec_valid",     to_ws_valid,  1);
      chk("vec_result",    to_ws_result, vt[i].exp);
      chk("vec_block",     fwd_block,    0);
      chk("vec_dest",      to_ws_dest,   32'(i + 1));
      chk_w("vec_payload", to_ws_pay,    saved_pay);
      step();
      data_ok = 0; rdata = $urandom();
      #1 chk("vec_after_valid", to_ws_valid, 0);
    end

    // ---------------- data held while WB stalls ----------------
    step(); idle();
    es_valid = 1; es_mem_req = 1; es_op = 2'd3; es_we = 1; es_dest = 5'd4;
    #1; step();
    es_valid = 0; es_mem_req = 0; ws_allowin = 0;
    data_ok = 1; rdata = 32'hAAAA_5555;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("hold_valid",   to_ws_valid,  1);
      chk("hold_result",  to_ws_result, 32'hAAAA_5555);
      chk("hold_allowin", ms_allowin,   0);
      step();
      data_ok = 0; rdata = $urandom();
    end
    ws_allowin = 1;
    #1;
    chk("hold_rel_valid",  to_ws_valid,  1);
    chk("hold_rel_result", to_ws_result, 32'hAAAA_5555);
    step();
    #1 chk("hold_done_valid", to_ws_valid, 0);

    // ---------------- flush with two orphaned responses ----------------
    step(); idle();
    es_valid = 1; es_mem_req = 1; es_op = 2'd3; es_we = 1; es_dest = 5'd5;
    #1; step();
    flush = 1;                      // load A resident, load B offered by EXE
    #1 chk("fl_valid", to_ws_valid, 0);
    step();
    flush = 0;
    es_dest = 5'd6;                 // load C
    #1 chk("fl_c_allowin", ms_allowin, 1);
    step();
    es_valid = 0; es_mem_req = 0;
    data_ok = 1; rdata = 32'h1111_1111;
    #1;
    chk("fl_drop1_valid", to_ws_valid, 0);
    chk("fl_drop1_block", fwd_block,   1);
    step();
    rdata = 32'h2222_2222;
    #1 chk("fl_drop2_valid", to_ws_valid, 0);
    step();
    rdata = 32'h3333_3333;
    #1;
    chk("fl_own_valid",  to_ws_valid,  1);
    chk("fl_own_result", to_ws_result, 32'h3333_3333);
    step();
    data_ok = 0;
    #1 chk("fl_done_valid", to_ws_valid, 0);

    // ---------------- back-to-back ALU ----------------
    step(); idle();
    for (int k = 0; k < 5; k++) begin
      es_valid = (k < 4);
      es_alu   = 32'hA000_0000 + k;
      es_we    = 1;
      es_dest  = 5'(10 + k);
      #1;
      if (k < 4) chk("b2b_allowin", ms_allowin, 1);
      if (k > 0) begin
        chk("b2b_valid",     to_ws_valid,  1);
        chk("b2b_result",    to_ws_result, 32'hA000_0000 + k - 1);
        chk("b2b_block",     fwd_block,    0);
        chk("b2b_fwd_valid", fwd_valid,    1);
      end
      step();
    end
    idle();

    // ---------------- async reset with an orphan pending ----------------
    step();
    es_valid = 1; es_mem_req = 1; es_op = 2'd3; es_we = 1; es_dest = 5'd8;
    #1; step();
    es_valid = 0; es_mem_req = 0; flush = 1;
    #1; step();
    flush = 0; ws_allowin = 0;
    es_valid = 1; es_op = 2'd0; es_alu = 32'h5; es_we = 1; es_dest = 5'd7; es_pay = rand_pay();
    #1; step();
    es_valid = 0;
    #1 chk("rstm_pre_fwd_valid", fwd_valid, 1);
    resetn = 0;
    #1;
    chk("rstm_valid",     to_ws_valid,  0);
    chk("rstm_result",    to_ws_result, 0);
    chk("rstm_dest",      to_ws_dest,   0);
    chk_w("rstm_payload", to_ws_pay,    '0);
    chk("rstm_fwd_valid", fwd_valid,    0);
    step(); step();
    resetn = 1; idle();
    es_valid = 1; es_mem_req = 1; es_op = 2'd3; es_we = 1; es_dest = 5'd9;
    #1; step();
    es_valid = 0; es_mem_req = 0;
    data_ok = 1; rdata = 32'h600D_600D;
    #1;
    chk("rstm_new_valid",  to_ws_valid,  1);
    chk("rstm_new_result", to_ws_result, 32'h600D_600D);
    step();
    idle();

    // ---------------- random traffic vs transaction model ----------------
    exe_v = 0; occ = 0; got = 0; nid = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (!exe_v && $urandom_range(0, 2) != 0) begin
        exe   = gen_ins(nid);
        nid++;
        exe_v = 1;
      end
      ws_allowin = ($urandom_range(0, 3) != 0);
      fl         = (sq.size() <= 1) && ($urandom_range(0, 24) == 0);
      dok        = (sq.size() > 0) && ($urandom_range(0, 2) == 0);
      es_valid   = exe_v;
      es_mem_req = exe_v & exe.mem;
      es_pay = exe.pay; es_op = exe.op; es_uns = exe.uns; es_lo = exe.lo;
      es_alu = exe.alu; es_we = exe.we; es_dest = exe.dest;
      data_ok = dok;
      rdata   = dok ? sq[0].rd : $urandom();
      flush   = fl;

      arrive    = dok && occ && (sq[0].id == res.id);
      rdy       = occ && (!res.mem || got || arrive);
      exp_valid = rdy && !fl;
      exp_allow = !occ || (rdy && ws_allowin);
      #1;
      chk("rnd_allowin",   ms_allowin,  exp_allow);
      chk("rnd_valid",     to_ws_valid, exp_valid);
      chk("rnd_fwd_valid", fwd_valid,   occ && res.we && (res.dest != 5'd0));
      chk("rnd_fwd_block", fwd_block,   occ && res.we && (res.op != 2'd0) && !rdy);
      if (occ) chk("rnd_fwd_dest", fwd_dest, res.dest);
      if (rdy && res.we && res.dest != 5'd0)
        chk("rnd_fwd_data", fwd_data, ld_model(res.op, res.uns, res.lo, res.rd, res.alu));
      if (exp_valid) begin
        chk("rnd_result",    to_ws_result, ld_model(res.op, res.uns, res.lo, res.rd, res.alu));
        chk("rnd_dest",      to_ws_dest,   res.dest);
        chk("rnd_we",        to_ws_we,     res.we);
        chk_w("rnd_payload", to_ws_pay,    res.pay);
      end

      if (dok) void'(sq.pop_front());
      if (fl) begin
        occ = 0;
        if (exe_v && exe.mem) sq.push_back('{exe.id, exe.rd});
        exe_v = 0;
      end else begin
        if (occ && rdy && ws_allowin) occ = 0;
        else if (arrive) got = 1;
        if (exe_v && exp_allow) begin
          res   = exe;
          occ   = 1;
          got   = 0;
          exe_v = 0;
          if (exe.mem) sq.push_back('{exe.id, exe.rd});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
